// File: rtl/axil_bram_banked.sv
// AXI4-Lite slave over NUM_BANKS dual-port block RAMs; port A serves AXI, port B the fabric.
// Define AXIL_BRAM_COLLISION_EN to drop AXI writes that hit the same word the fabric writes.

module axil_bram_banked_bank #(
    parameter int DW  = 32,
    parameter int AWD = 10,
    parameter int LAT = 1
) (
    input  logic            clk,
    input  logic            a_en,
    input  logic [DW/8-1:0] a_we,
    input  logic [AWD-1:0]  a_addr,
    input  logic [DW-1:0]   a_din,
    output logic [DW-1:0]   a_dout,
    input  logic            b_we,
    input  logic [AWD-1:0]  b_addr,
    input  logic [DW-1:0]   b_din,
    output logic [DW-1:0]   b_dout
);
    logic [DW-1:0] mem [2**AWD];
    logic [DW-1:0] a_q, b_q;

    // Port B is written after port A so a same-word write from the fabric wins.
    always_ff @(posedge clk) begin
        if (a_en) begin
            for (int k = 0; k < DW/8; k++)
                if (a_we[k]) mem[a_addr][k*8 +: 8] <= a_din[k*8 +: 8];
            a_q <= mem[a_addr];
        end
        if (b_we) mem[b_addr] <= b_din;
        b_q <= mem[b_addr];
    end

    if (LAT == 2) begin : g_outreg
        logic [DW-1:0] a_pipe_q, b_pipe_q;
        always_ff @(posedge clk) begin
            a_pipe_q <= a_q;
            b_pipe_q <= b_q;
        end
        assign a_dout = a_pipe_q;
        assign b_dout = b_pipe_q;
    end else begin : g_direct
        assign a_dout = a_q;
        assign b_dout = b_q;
    end
endmodule

module axil_bram_banked #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int NUM_BANKS   = 4,
    parameter int RAM_LATENCY = 1,
    localparam int BW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int AW = ADDR_WIDTH + BW + 2,
    localparam int SW = DATA_WIDTH / 8
) (
    input  logic                            axi_clock,
    input  logic                            rst_n,
    input  logic [AW-1:0]                   s_axil_awaddr,
    input  logic [2:0]                      s_axil_awprot,
    input  logic                            s_axil_awvalid,
    output logic                            s_axil_awready,
    input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
    input  logic [SW-1:0]                   s_axil_wstrb,
    input  logic                            s_axil_wvalid,
    output logic                            s_axil_wready,
    output logic [1:0]                      s_axil_bresp,
    output logic                            s_axil_bvalid,
    input  logic                            s_axil_bready,
    input  logic [AW-1:0]                   s_axil_araddr,
    input  logic [2:0]                      s_axil_arprot,
    input  logic                            s_axil_arvalid,
    output logic                            s_axil_arready,
    output logic [DATA_WIDTH-1:0]           s_axil_rdata,
    output logic [1:0]                      s_axil_rresp,
    output logic                            s_axil_rvalid,
    input  logic                            s_axil_rready,
    input  logic [NUM_BANKS*ADDR_WIDTH-1:0] fpga_addr,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] fpga_din,
    input  logic [NUM_BANKS-1:0]            fpga_we,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] fpga_dout,
    output logic [15:0]                     collision_cnt
);
    typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RWAIT, RDATA} state_t;

    state_t state_q, state_d;
    logic rr_q, rr_d;  // 0: write wins a tie, 1: read wins
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_mux;
    logic [BW-1:0] rd_bank_q, rd_bank_d;
    logic rd_err_q, rd_err_d;
    logic [RAM_LATENCY:0] vld_pipe;
    logic [RAM_LATENCY:1] vld_pipe_q;
    logic [15:0] cnt_q, cnt_d;

    logic [ADDR_WIDTH-1:0] aw_word, ar_word;
    logic [BW-1:0] aw_bank, ar_bank;
    logic aw_ok, ar_ok, collision;
    logic [NUM_BANKS-1:0] wr_sel, rd_sel, coll;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] a_dout;

    assign aw_word = s_axil_awaddr[ADDR_WIDTH+1:2];
    assign ar_word = s_axil_araddr[ADDR_WIDTH+1:2];
    assign aw_bank = s_axil_awaddr[AW-1:ADDR_WIDTH+2];
    assign ar_bank = s_axil_araddr[AW-1:ADDR_WIDTH+2];
    assign aw_ok   = 32'(aw_bank) < NUM_BANKS;
    assign ar_ok   = 32'(ar_bank) < NUM_BANKS;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        logic a_en;
        assign wr_sel[i] = (state_q == WR) && aw_ok && (aw_bank == BW'(i));
        assign rd_sel[i] = (state_q == RD) && ar_ok && (ar_bank == BW'(i));
        assign coll[i]   = wr_sel[i] && fpga_we[i] &&
                           (fpga_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == aw_word);
`ifdef AXIL_BRAM_COLLISION_EN
        assign a_en = (wr_sel[i] && !coll[i]) || rd_sel[i];
`else
        assign a_en = wr_sel[i] || rd_sel[i];
`endif
        axil_bram_banked_bank #(.DW(DATA_WIDTH), .AWD(ADDR_WIDTH), .LAT(RAM_LATENCY)) u_bank (
            .clk    (axi_clock),
            .a_en   (a_en),
            .a_we   (wr_sel[i] ? s_axil_wstrb : '0),
            .a_addr ((state_q == WR) ? aw_word : ar_word),
            .a_din  (s_axil_wdata),
            .a_dout (a_dout[i]),
            .b_we   (fpga_we[i]),
            .b_addr (fpga_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .b_din  (fpga_din[i*DATA_WIDTH +: DATA_WIDTH]),
            .b_dout (fpga_dout[i*DATA_WIDTH +: DATA_WIDTH])
        );
    end

`ifdef AXIL_BRAM_COLLISION_EN
    assign collision = |coll;
`else
    assign collision = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            if (rd_bank_q == BW'(b)) rd_mux = a_dout[b];
    end

    // vld_pipe[k] is high k cycles after the read address was presented.
    assign vld_pipe[0] = (state_q == RD);
    assign vld_pipe[RAM_LATENCY:1] = vld_pipe_q;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        rd_bank_d = rd_bank_q;
        rd_err_d  = rd_err_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: begin
                if (s_axil_awvalid && s_axil_wvalid && (!s_axil_arvalid || !rr_q)) begin
                    state_d = WR;
                    rr_d    = 1'b1;
                end else if (s_axil_arvalid) begin
                    state_d = RD;
                    rr_d    = 1'b0;
                end
            end
            WR: begin
                state_d = WRESP;
                bresp_d = !aw_ok ? 2'b11 : (collision ? 2'b10 : 2'b00);
                if (collision && !(&cnt_q)) cnt_d = cnt_q + 16'd1;
            end
            WRESP: if (s_axil_bready) state_d = IDLE;
            RD: begin
                state_d   = RWAIT;
                rd_bank_d = ar_bank;
                rd_err_d  = !ar_ok;
            end
            RWAIT: begin
                if (vld_pipe[RAM_LATENCY]) begin
                    state_d = RDATA;
                    rdata_d = rd_err_q ? '0 : rd_mux;
                    rresp_d = rd_err_q ? 2'b11 : 2'b00;
                end
            end
            RDATA: if (s_axil_rready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            bresp_q    <= 2'b00;
            rresp_q    <= 2'b00;
            rdata_q    <= '0;
            rd_bank_q  <= '0;
            rd_err_q   <= 1'b0;
            vld_pipe_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_bank_q  <= rd_bank_d;
            rd_err_q   <= rd_err_d;
            vld_pipe_q <= vld_pipe[RAM_LATENCY-1:0];
            cnt_q      <= cnt_d;
        end
    end

    assign s_axil_awready = (state_q == WR);
    assign s_axil_wready  = (state_q == WR);
    assign s_axil_bvalid  = (state_q == WRESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = (state_q == RD);
    assign s_axil_rvalid  = (state_q == RDATA);
    assign s_axil_rresp   = rresp_q;
    assign s_axil_rdata   = rdata_q;
    assign collision_cnt  = cnt_q;

    logic unused_ok;
    assign unused_ok = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0], s_axil_awprot, s_axil_arprot, collision};
endmodule

// File: tb/tb_axil_bram_banked.sv
// Directed self-checking bench for axil_bram_banked (3 banks, so bank 3 decodes to DECERR).

module tb_axil_bram_banked;
    localparam int DW = 32, ADW = 10, NB = 3, LAT = 1;
    localparam int AW = ADW + 2 + 2;

    logic clk = 1'b0;
    logic rst_n;
    logic [AW-1:0] awaddr, araddr;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [NB*ADW-1:0] fpga_addr;
    logic [NB*DW-1:0] fpga_din, fpga_dout;
    logic [NB-1:0] fpga_we;
    logic [15:0] collision_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axil_bram_banked #(.DATA_WIDTH(DW), .ADDR_WIDTH(ADW), .NUM_BANKS(NB), .RAM_LATENCY(LAT)) dut (
        .axi_clock(clk), .rst_n(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(3'b000), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .fpga_addr(fpga_addr), .fpga_din(fpga_din), .fpga_we(fpga_we), .fpga_dout(fpga_dout),
        .collision_cnt(collision_cnt)
    );

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        int n;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
        if (!awready) begin checks++; errors++; $display("FAIL wr_awready_timeout got 0 want 1"); end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!bvalid) begin checks++; errors++; $display("FAIL wr_bvalid_timeout got 0 want 1"); end
        resp = bvalid ? bresp : 2'bxx;
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
        int n;
        araddr = a; arvalid = 1; rready = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 50);
        if (!arready) begin checks++; errors++; $display("FAIL rd_arready_timeout got 0 want 1"); end
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        if (!rvalid) begin checks++; errors++; $display("FAIL rd_rvalid_timeout got 0 want 1"); end
        d = rvalid ? rdata : 'x;
        resp = rvalid ? rresp : 2'bxx;
        @(posedge clk); #1;
    endtask

    task automatic fab_read(input int bank, input logic [ADW-1:0] a, output logic [31:0] d);
        fpga_addr[bank*ADW +: ADW] = a;
        repeat (LAT) @(posedge clk);
        #1;
        d = fpga_dout[bank*DW +: DW];
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        checks++;
        if ({awready, wready, bvalid, arready, rvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_handshake got %b want 00000", {awready, wready, bvalid, arready, rvalid});
        end
        checks++;
        if ({bresp, rresp} !== 4'b0) begin errors++; $display("FAIL reset_resp got %b want 0000", {bresp, rresp}); end
        checks++;
        if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++;
        if (collision_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h want 0", collision_cnt); end
    endtask

    task automatic test_write_fabric();
        logic [1:0] r; logic [31:0] d;
        axi_write(14'h0104, 32'hDEADBEEF, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL wr_bresp got %b want 00", r); end
        fab_read(0, 10'd65, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin errors++; $display("FAIL fab_dout got %h want deadbeef", d); end
    endtask

    task automatic test_strobe();
        logic [1:0] r; logic [31:0] d;
        axi_write(14'h0200, 32'h11223344, 4'hF, r);
        axi_write(14'h0200, 32'hAABBCCDD, 4'b0101, r);
        axi_read(14'h0200, d, r);
        checks++;
        if (d !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_rdata got %h want 11bb33dd", d); end
        checks++;
        if (r !== 2'b00) begin errors++; $display("FAIL strobe_rresp got %b want 00", r); end
    endtask

    task automatic test_back_to_back();
        byte order[4];
        int rq[2], rv[2];
        logic [31:0] rd[2];
        int g = 0, nr = 0, nv = 0, cyc = 0;
        logic prev_rv = 0;
        rst_n = 0;
        awaddr = 14'h0000; wdata = 32'h00001234; wstrb = 4'hF; araddr = 14'h0000;
        awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        while ((g < 4 || nv < 2) && cyc < 80) begin
            @(posedge clk); #1; cyc++;
            if (g >= 4) begin awvalid = 0; wvalid = 0; arvalid = 0; end
            if (awready && g < 4) begin order[g] = "W"; g++; end
            if (arready && g < 4) begin order[g] = "R"; g++; if (nr < 2) begin rq[nr] = cyc; nr++; end end
            if (rvalid && !prev_rv && nv < 2) begin rv[nv] = cyc; rd[nv] = rdata; nv++; end
            prev_rv = rvalid;
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        checks++;
        if (g != 4 || nv != 2) begin errors++; $display("FAIL arb_timeout grants=%0d rvalids=%0d want 4 2", g, nv); end
        else begin
            checks++;
            if ({order[0], order[1], order[2], order[3]} !== {"W", "R", "W", "R"})
                begin errors++; $display("FAIL arb_order got %s%s%s%s want WRWR", order[0], order[1], order[2], order[3]); end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (rv[k] - rq[k] != 1 + LAT)
                    begin errors++; $display("FAIL arb_rlat%0d got %0d want %0d", k, rv[k] - rq[k], 1 + LAT); end
                checks++;
                if (rd[k] !== 32'h00001234) begin errors++; $display("FAIL arb_rdata%0d got %h want 00001234", k, rd[k]); end
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_decerr();
        logic [1:0] r; logic [31:0] d;
        for (int b = 0; b < NB; b++) begin
            fpga_addr[b*ADW +: ADW] = '0;
            fpga_din[b*DW +: DW] = 32'hA0 + b;
        end
        fpga_we = '1;
        @(posedge clk); #1;
        fpga_we = '0;
        axi_write(14'h3000, 32'hFFFFFFFF, 4'hF, r);
        checks++;
        if (r !== 2'b11) begin errors++; $display("FAIL decerr_bresp got %b want 11", r); end
        axi_read(14'h3000, d, r);
        checks++;
        if (r !== 2'b11) begin errors++; $display("FAIL decerr_rresp got %b want 11", r); end
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL decerr_rdata got %h want 0", d); end
        for (int b = 0; b < NB; b++) begin
            fab_read(b, 10'd0, d);
            checks++;
            if (d !== 32'hA0 + b) begin errors++; $display("FAIL decerr_bank%0d got %h want %h", b, d, 32'hA0 + b); end
        end
    endtask

    task automatic test_collision();
        logic [31:0] d; int n;
        awaddr = 14'h1014; wdata = 32'h9; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 50);
        fpga_addr[1*ADW +: ADW] = 10'd5; fpga_din[1*DW +: DW] = 32'h5; fpga_we[1] = 1;
        @(posedge clk); #1;
        fpga_we = '0; awvalid = 0; wvalid = 0;
        checks++;
        if (!bvalid) begin errors++; $display("FAIL coll_bvalid got 0 want 1"); end
`ifdef AXIL_BRAM_COLLISION_EN
        checks++;
        if (bresp !== 2'b10) begin errors++; $display("FAIL coll_bresp got %b want 10", bresp); end
        @(posedge clk); #1;
        checks++;
        if (collision_cnt !== 16'd1) begin errors++; $display("FAIL coll_cnt got %0d want 1", collision_cnt); end
`else
        checks++;
        if (bresp !== 2'b00) begin errors++; $display("FAIL coll_bresp got %b want 00", bresp); end
        @(posedge clk); #1;
        checks++;
        if (collision_cnt !== 16'd0) begin errors++; $display("FAIL coll_cnt got %0d want 0", collision_cnt); end
`endif
        fab_read(1, 10'd5, d);
        checks++;
        if (d !== 32'h5) begin errors++; $display("FAIL coll_word got %h want 5", d); end
    endtask

    task automatic test_reset_midread();
        logic [1:0] r; logic [31:0] d; int n;
        axi_write(14'h201C, 32'hCAFEF00D, 4'hF, r);
        araddr = 14'h201C; arvalid = 1; rready = 0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 50);
        @(posedge clk); #1;
        arvalid = 0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (!rvalid) begin errors++; $display("FAIL midrd_rvalid got 0 want 1"); end
        #2;
        rst_n = 0;
        #1;
        checks++;
        if (rvalid !== 1'b0) begin errors++; $display("FAIL midrd_async_drop got %b want 0", rvalid); end
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        axi_read(14'h201C, d, r);
        checks++;
        if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL midrd_readback got %h want cafef00d", d); end
    endtask

    initial begin
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0;
        fpga_addr = '0; fpga_din = '0; fpga_we = '0;
        test_reset();
        test_write_fabric();
        test_strobe();
        test_back_to_back();
        test_decerr();
        test_collision();
        test_reset_midread();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/axil_bram_banked.md
# axil_bram_banked

AXI4-Lite slave that exposes NUM_BANKS independent block RAMs to the PS, each with a second port owned by fabric logic on the same clock. Next generation of the single-bank AXI-Lite BRAM bridge. It adds full read/write arbitration (reads and writes may be requested simultaneously), WSTRB byte enables, bank decoding with DECERR, configurable RAM read latency and optional write-collision detection. It sits between the PS AXI-Lite interconnect and fabric producers/consumers: capture buffers and coefficient tables.

## Interface
- DATA_WIDTH, 32, word width; multiple of 8.
- ADDR_WIDTH, 10, word-address width per bank (depth 2**ADDR_WIDTH).
- NUM_BANKS, 4, number of banks, 1..16.
- RAM_LATENCY, 1, RAM read latency in cycles, 1 or 2 (2 adds an output register).
- Derived: BW = max(1,$clog2(NUM_BANKS)); AW = ADDR_WIDTH+BW+2.

Ports:
- axi_clock  in  1  single clock for AXI and fabric sides.
- rst_n  in  1  asynchronous, active-low reset.
- s_axil_awaddr/awprot/awvalid/awready  AW channel; awaddr AW bits, awprot 3 bits (ignored).
- s_axil_wdata/wstrb/wvalid/wready  W channel; DATA_WIDTH, DATA_WIDTH/8.
- s_axil_bresp/bvalid/bready  B channel; bresp 2 bits.
- s_axil_araddr/arprot/arvalid/arready  AR channel; araddr AW bits.
- s_axil_rdata/rresp/rvalid/rready  R channel.
- fpga_addr  in  NUM_BANKS*ADDR_WIDTH  per-bank fabric word address, bank i at slice i.
- fpga_din  in  NUM_BANKS*DATA_WIDTH  per-bank fabric write data.
- fpga_we  in  NUM_BANKS  per-bank full-word write enable.
- fpga_dout  out  NUM_BANKS*DATA_WIDTH  per-bank read data, RAM_LATENCY cycles after address.
- collision_cnt  out  16  saturating collision count (see Configuration).

## Operation
- Address decode:
  - awaddr/araddr[1:0] ignored.
  - Word index = addr[ADDR_WIDTH+1:2].
  - Bank = addr[AW-1:ADDR_WIDTH+2].
  - Bank >= NUM_BANKS: no RAM access, response DECERR (2'b11), rdata = 0.
- FSM states: IDLE, WR, WRESP, RD, RWAIT, RDATA.
- IDLE:
  - Write pending = awvalid && wvalid. AW alone or W alone is never accepted.
  - Read pending = arvalid.
  - One pending: grant it.
  - Both pending: grant per 1-bit round-robin pointer. Pointer resets to "write first".
  - Pointer always flips to favour the other type after any grant.
- WR: awready=wready=1 for one cycle. Write issued to the selected bank port A with byte enables = wstrb. Next state WRESP.
- WRESP: bvalid=1 with bresp held until bready; then IDLE.
- RD: arready=1 for one cycle, address presented to the port. Next state RWAIT.
- RWAIT: waits RAM_LATENCY cycles, captures data into the rdata register. Next state RDATA.
- RDATA: rvalid=1 until rready; rdata/rresp stable while rvalid && !rready.
- Fabric port B: always enabled, read-first (fpga_dout shows the old word on the write cycle). Full-word writes only.
- AXI port A: single operation per cycle; no read-during-write case arises.

## Timing
- Reset (asynchronous assert, synchronous deassert from the clock edge):
  - All ready/valid outputs = 0; bresp = rresp = 0; rdata = 0; collision_cnt = 0.
  - FSM to IDLE; pointer = write first.
  - RAM contents retained; any in-flight transaction abandoned with no response.
- Write, request sampled in IDLE at edge T:
  - awready/wready high in cycle T+1; RAM written at the end of T+1.
  - bvalid from T+2. Back-to-back write throughput = 3 cycles + bready stall.
- Read, request sampled at T:
  - arready high in T+1; rvalid from T+2+RAM_LATENCY.
  - Read of an address written by the previous AXI write returns the new data.
- Fabric: fpga_dout[i] valid RAM_LATENCY cycles after fpga_addr[i].

## Configuration
- AXIL_BRAM_COLLISION_EN defined:
  - Collision = AXI write (WR state) and fpga_we on the same bank and same word in the same cycle.
  - On collision the AXI write is dropped, bresp = SLVERR (2'b10), collision_cnt increments (saturates at 16'hFFFF).
  - The fabric write takes effect.
- Undefined:
  - No detection; bresp OKAY; collision_cnt tied to 0.
  - Both writes issued; fabric write wins deterministically (port B applied after port A); AXI bytes not written by port B cannot be relied upon.

## Test plan
- Reset then AXI write 0xDEADBEEF, wstrb 4'hF to 0x0000_0104 (bank 0, word 65) -> bresp 0; fpga_dout[0] = 0xDEADBEEF RAM_LATENCY cycles after fpga_addr[0]=65.
- Write 0x11223344 full word, then 0xAABBCCDD with wstrb 4'b0101 to the same address; AXI read back -> 0x11BB33DD, rresp 0.
- awvalid, wvalid, arvalid all held high from reset for 4 grants -> order W,R,W,R; rvalid exactly 2+RAM_LATENCY cycles after its request sample.
- NUM_BANKS=3, read from bank 3 -> rresp 2'b11, rdata 0; write to bank 3 -> bresp 2'b11, no bank modified.
- Fabric writes bank 1 word 5 with 0x5 in the same cycle as the AXI write of 0x9 there -> with macro: bresp 2'b10, collision_cnt=1, word=0x5; without: bresp 0, word=0x5.
- rst_n pulled low while rvalid high and rready low -> rvalid drops asynchronously; after release, read of previously written data returns the stored value.
